flow_monitor: RTL and testbench

Synthesizable receive-side sink for the GPStudio pixel flow (`fv`/`dv`/`data`). It sits at the output of a processing block such as `norm`, or at any flow tap. It measures each frame on the fly: pixel count, min, max, sum and an optional CRC. Results of the last complete frame are exposed on the standard slave register bus (`addr_rel_i`/`wr_i`/`rd_i`), so benches and firmware can check a stream without dumping it.

---
 rtl/flow_monitor_pkg.sv | 32 +++
 rtl/flow_monitor_crc16.sv | 39 +++
 rtl/flow_monitor.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_flow_monitor.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_monitor_pkg.sv
// -----------------------------------------------------------------------------
// flow_monitor_pkg
// Shared definitions for the flow_monitor pixel-flow sink:
//   - register index constants for the slave register bus
//   - measurement FSM state encoding
//   - CRC-16/CCITT polynomial and seed
// No ports (package).
// -----------------------------------------------------------------------------
package flow_monitor_pkg;

    // Register map indices (addr_rel_i)
    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_FRAME_CNT = 3'd1;
    localparam logic [2:0] REG_PIX_CNT   = 3'd2;
    localparam logic [2:0] REG_MINMAX    = 3'd3;
    localparam logic [2:0] REG_SUM       = 3'd4;
    localparam logic [2:0] REG_CRC       = 3'd5;
    localparam logic [2:0] REG_STATUS    = 3'd6;

    // Measurement FSM
    typedef enum logic [1:0] {
        DISABLED   = 2'd0,
        WAIT_IDLE  = 2'd1,
        WAIT_FRAME = 2'd2,
        IN_FRAME   = 2'd3
    } state_e;

    // CRC-16/CCITT-FALSE parameters
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/flow_monitor_crc16.sv
// -----------------------------------------------------------------------------
// flow_monitor_crc16
// Combinational next-CRC for one 16-bit pixel, CRC-16/CCITT, MSB first.
// Ports:
//   crc_i  [15:0] in  : current CRC value
//   data_i [15:0] in  : pixel to fold into the CRC
//   crc_o  [15:0] out : CRC after consuming data_i
// -----------------------------------------------------------------------------
module flow_monitor_crc16
    import flow_monitor_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    // Because the data word and the CRC are the same width, XOR-ing the whole
    // word into the register up front and then shifting 16 times is identical
    // to the classic bit-serial form with per-bit feedback.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                               input logic [15:0] data);
        logic [15:0] c;
        c = crc ^ data;
        for (int i = 0; i < 16; i++) begin
            if (c[15]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    // Next-CRC evaluation
    always_comb begin
        crc_o = crc16_next(crc_i, data_i);
    end

endmodule

// File: rtl/flow_monitor.sv
// -----------------------------------------------------------------------------
// flow_monitor
// Receive-side sink for the pixel flow (fv/dv/data). Measures each whole frame
// (pixel count, min, max, sum, optional CRC-16) and exposes the results of the
// last completed frame on the slave register bus.
// Optional feature: define FLOW_MONITOR_CRC_EN to build the CRC-16/CCITT
// accumulator; otherwise no CRC logic exists and register 5 reads 0.
// Ports:
//   clk                      in  : processing clock
//   reset_n                  in  : synchronous active-low reset
//   in_fv / in_dv            in  : frame valid / data valid
//   in_data [DATA_WIDTH-1:0] in  : pixel data
//   addr_rel_i [2:0]         in  : register index
//   wr_i / datawr_i [31:0]   in  : register write strobe / data
//   rd_i                     in  : register read strobe
//   datard_o [31:0]          out : registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module flow_monitor
    import flow_monitor_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_fv,
    input  logic                  in_dv,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [2:0]            addr_rel_i,
    input  logic                  wr_i,
    input  logic [31:0]           datawr_i,
    input  logic                  rd_i,
    output logic [31:0]           datard_o
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_MAX = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // Control / status state
    state_e                 state_q, state_d;
    logic                   enable_q, enable_d;
    logic                   pix_ovf_q, pix_ovf_d;
    logic                   dv_outside_q, dv_outside_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;

    // Working accumulators for the open frame
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  min_q, min_d;
    logic [DATA_WIDTH-1:0]  max_q, max_d;
    logic [31:0]            sum_q, sum_d;

    // Results of the last committed frame
    logic [CNT_WIDTH-1:0]   res_cnt_q, res_cnt_d;
    logic [DATA_WIDTH-1:0]  res_min_q, res_min_d;
    logic [DATA_WIDTH-1:0]  res_max_q, res_max_d;
    logic [31:0]            res_sum_q, res_sum_d;

    logic [31:0]            datard_q, datard_d;
    logic [31:0]            rd_data_s;

    // Decoded events
    logic                   clear_s;
    logic                   ctrl_wr_s;
    logic                   start_s;
    logic                   acc_s;
    logic                   commit_s;
    logic                   ovf_set_s;
    logic                   unused_s;

    // Accumulator base values (fresh init on frame start, else running value)
    logic [CNT_WIDTH-1:0]   cnt_b_s;
    logic [DATA_WIDTH-1:0]  min_b_s;
    logic [DATA_WIDTH-1:0]  max_b_s;
    logic [31:0]            sum_b_s;

`ifdef FLOW_MONITOR_CRC_EN
    logic [15:0]            crc_q, crc_d;
    logic [15:0]            res_crc_q, res_crc_d;
    logic [15:0]            crc_b_s;
    logic [15:0]            crc_next_s;
`endif

    // Upper write-data bits have no register behind them
    always_comb begin
        unused_s = ^datawr_i[31:2];
    end

    // Register-bus and flow event decode
    always_comb begin
        ctrl_wr_s = wr_i && (addr_rel_i == REG_CTRL);
        clear_s   = ctrl_wr_s && datawr_i[1];
        // Frame opens on the WAIT_FRAME->IN_FRAME edge; a dv on that same
        // edge is the first pixel of the frame.
        start_s   = enable_q && (state_q == WAIT_FRAME) && in_fv;
        acc_s     = in_dv && in_fv && enable_q &&
                    ((state_q == WAIT_FRAME) || (state_q == IN_FRAME));
        commit_s  = enable_q && (state_q == IN_FRAME) && !in_fv;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        if (!enable_q) begin
            state_d = DISABLED;
        end else begin
            case (state_q)
                DISABLED: begin
                    state_d = WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    // Skip any frame already in progress when enabled
                    if (!in_fv) begin
                        state_d = WAIT_FRAME;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
                WAIT_FRAME: begin
                    if (in_fv) begin
                        state_d = IN_FRAME;
                    end else begin
                        state_d = WAIT_FRAME;
                    end
                end
                IN_FRAME: begin
                    if (!in_fv) begin
                        state_d = WAIT_FRAME;
                    end else begin
                        state_d = IN_FRAME;
                    end
                end
                default: begin
                    state_d = DISABLED;
                end
            endcase
        end
    end

    // CTRL.enable; clear is a pulse and is not stored
    always_comb begin
        if (ctrl_wr_s) begin
            enable_d = datawr_i[0];
        end else begin
            enable_d = enable_q;
        end
    end

    // Working accumulator base selection and per-pixel update
    always_comb begin
        if (start_s) begin
            cnt_b_s = CNT_ZERO;
            min_b_s = DATA_MAX;
            max_b_s = DATA_ZERO;
            sum_b_s = 32'h0000_0000;
        end else begin
            cnt_b_s = cnt_q;
            min_b_s = min_q;
            max_b_s = max_q;
            sum_b_s = sum_q;
        end

        cnt_d     = cnt_b_s;
        min_d     = min_b_s;
        max_d     = max_b_s;
        sum_d     = sum_b_s;
        ovf_set_s = 1'b0;
        if (acc_s) begin
            // Pixel count saturates instead of wrapping
            if (cnt_b_s == CNT_MAX) begin
                cnt_d     = cnt_b_s;
                ovf_set_s = 1'b1;
            end else begin
                cnt_d     = cnt_b_s + CNT_ONE;
                ovf_set_s = 1'b0;
            end
            if (in_data < min_b_s) begin
                min_d = in_data;
            end else begin
                min_d = min_b_s;
            end
            if (in_data > max_b_s) begin
                max_d = in_data;
            end else begin
                max_d = max_b_s;
            end
            sum_d = sum_b_s + 32'(in_data);
        end else begin
            cnt_d     = cnt_b_s;
            min_d     = min_b_s;
            max_d     = max_b_s;
            sum_d     = sum_b_s;
            ovf_set_s = 1'b0;
        end
    end

`ifdef FLOW_MONITOR_CRC_EN
    // CRC base: seed on frame start, else running value
    always_comb begin
        if (start_s) begin
            crc_b_s = CRC_INIT;
        end else begin
            crc_b_s = crc_q;
        end
    end

    flow_monitor_crc16 u_crc16 (
        .crc_i  (crc_b_s),
        .data_i (16'(in_data)),
        .crc_o  (crc_next_s)
    );

    // CRC accumulator update
    always_comb begin
        if (acc_s) begin
            crc_d = crc_next_s;
        end else begin
            crc_d = crc_b_s;
        end
    end

    // CRC result: clear beats a coincident commit
    always_comb begin
        if (clear_s) begin
            res_crc_d = 16'h0000;
        end else if (commit_s) begin
            res_crc_d = crc_q;
        end else begin
            res_crc_d = res_crc_q;
        end
    end
`endif

    // Result registers, frame counter and sticky flags; clear beats commit
    always_comb begin
        if (clear_s) begin
            frame_cnt_d  = CNT_ZERO;
            res_cnt_d    = CNT_ZERO;
            res_min_d    = DATA_ZERO;
            res_max_d    = DATA_ZERO;
            res_sum_d    = 32'h0000_0000;
            pix_ovf_d    = 1'b0;
            dv_outside_d = 1'b0;
        end else begin
            if (commit_s) begin
                frame_cnt_d = frame_cnt_q + CNT_ONE;
                res_cnt_d   = cnt_q;
                res_min_d   = min_q;
                res_max_d   = max_q;
                res_sum_d   = sum_q;
            end else begin
                frame_cnt_d = frame_cnt_q;
                res_cnt_d   = res_cnt_q;
                res_min_d   = res_min_q;
                res_max_d   = res_max_q;
                res_sum_d   = res_sum_q;
            end
            pix_ovf_d    = pix_ovf_q | ovf_set_s;
            dv_outside_d = dv_outside_q | (in_dv & ~in_fv);
        end
    end

    // Register read multiplexer
    always_comb begin
        case (addr_rel_i)
            REG_CTRL:      rd_data_s = {31'h0000_0000, enable_q};
            REG_FRAME_CNT: rd_data_s = 32'(frame_cnt_q);
            REG_PIX_CNT:   rd_data_s = 32'(res_cnt_q);
            REG_MINMAX:    rd_data_s = {16'(res_max_q), 16'(res_min_q)};
            REG_SUM:       rd_data_s = res_sum_q;
`ifdef FLOW_MONITOR_CRC_EN
            REG_CRC:       rd_data_s = {16'h0000, res_crc_q};
`else
            REG_CRC:       rd_data_s = 32'h0000_0000;
`endif
            REG_STATUS:    rd_data_s = {29'h0000_0000, dv_outside_q, pix_ovf_q,
                                        (state_q == IN_FRAME)};
            default:       rd_data_s = 32'h0000_0000;
        endcase
    end

    // Read data holds until the next read strobe
    always_comb begin
        if (rd_i) begin
            datard_d = rd_data_s;
        end else begin
            datard_d = datard_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= DISABLED;
            enable_q     <= 1'b0;
            pix_ovf_q    <= 1'b0;
            dv_outside_q <= 1'b0;
            frame_cnt_q  <= CNT_ZERO;
            cnt_q        <= CNT_ZERO;
            min_q        <= DATA_ZERO;
            max_q        <= DATA_ZERO;
            sum_q        <= 32'h0000_0000;
            res_cnt_q    <= CNT_ZERO;
            res_min_q    <= DATA_ZERO;
            res_max_q    <= DATA_ZERO;
            res_sum_q    <= 32'h0000_0000;
            datard_q     <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            pix_ovf_q    <= pix_ovf_d;
            dv_outside_q <= dv_outside_d;
            frame_cnt_q  <= frame_cnt_d;
            cnt_q        <= cnt_d;
            min_q        <= min_d;
            max_q        <= max_d;
            sum_q        <= sum_d;
            res_cnt_q    <= res_cnt_d;
            res_min_q    <= res_min_d;
            res_max_q    <= res_max_d;
            res_sum_q    <= res_sum_d;
            datard_q     <= datard_d;
        end
    end

`ifdef FLOW_MONITOR_CRC_EN
    // CRC registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            crc_q     <= 16'h0000;
            res_crc_q <= 16'h0000;
        end else begin
            crc_q     <= crc_d;
            res_crc_q <= res_crc_d;
        end
    end
`endif

    assign datard_o = datard_q;

endmodule

// File: tb/tb_flow_monitor.sv
// -----------------------------------------------------------------------------
// tb_flow_monitor
// Directed plus random self-checking bench for flow_monitor. Inputs change on
// the falling edge; register reads push the expected value to a scoreboard
// queue and pop/compare it once datard_o has been updated.
// -----------------------------------------------------------------------------
module tb_flow_monitor;
    import flow_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_fv;
    logic        in_dv;
    logic [15:0] in_data;
    logic [2:0]  addr_rel_i;
    logic        wr_i;
    logic [31:0] datawr_i;
    logic        rd_i;
    logic [31:0] datard_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    // Reference model of the frame being sent
    logic [31:0] m_cnt;
    logic [15:0] m_min;
    logic [15:0] m_max;
    logic [31:0] m_sum;
    logic [15:0] m_crc;

    always #5 clk = ~clk;

    flow_monitor #(.DATA_WIDTH(16), .CNT_WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_fv      (in_fv),
        .in_dv      (in_dv),
        .in_data    (in_data),
        .addr_rel_i (addr_rel_i),
        .wr_i       (wr_i),
        .datawr_i   (datawr_i),
        .rd_i       (rd_i),
        .datard_o   (datard_o)
    );

    // Bit-serial CRC-16/CCITT reference
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_exp(input logic [15:0] c);
`ifdef FLOW_MONITOR_CRC_EN
        return {16'h0000, c};
`else
        return 32'h0000_0000;
`endif
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic fv, input logic dv, input logic [15:0] d);
        in_fv = fv; in_dv = dv; in_data = d;
        @(negedge clk);
    endtask

    task automatic model_start();
        m_cnt = 32'd0; m_min = 16'hFFFF; m_max = 16'h0000; m_sum = 32'd0; m_crc = 16'hFFFF;
    endtask

    task automatic send_pix(input logic [15:0] d);
        m_cnt = m_cnt + 32'd1;
        if (d < m_min) m_min = d;
        if (d > m_max) m_max = d;
        m_sum = m_sum + {16'h0000, d};
        m_crc = crc_ref(m_crc, d);
        cyc(1'b1, 1'b1, d);
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        addr_rel_i = a; datawr_i = d; wr_i = 1'b1;
        @(negedge clk);
        wr_i = 1'b0;
    endtask

    // Read: expectation queued with the strobe, compared after the edge
    task automatic reg_rd(input logic [2:0] a, input logic [31:0] exp, input string tag,
                          input logic do_wr = 1'b0, input logic [31:0] wd = 32'h0);
        logic [31:0] e;
        string       t;
        addr_rel_i = a; rd_i = 1'b1; wr_i = do_wr; datawr_i = wd;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        rd_i = 1'b0; wr_i = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_val(t, datard_o, e);
    endtask

    task automatic check_model(input logic [31:0] fc, input string pfx);
        reg_rd(REG_PIX_CNT,   m_cnt,           {pfx, "_pix_cnt"});
        reg_rd(REG_MINMAX,    {m_max, m_min},  {pfx, "_minmax"});
        reg_rd(REG_SUM,       m_sum,           {pfx, "_sum"});
        reg_rd(REG_CRC,       crc_exp(m_crc),  {pfx, "_crc"});
        reg_rd(REG_FRAME_CNT, fc,              {pfx, "_frame_cnt"});
    endtask

    initial begin
        int n;
        reset_n = 1'b0; in_fv = 1'b0; in_dv = 1'b0; in_data = 16'h0;
        addr_rel_i = 3'd0; wr_i = 1'b0; datawr_i = 32'h0; rd_i = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_datard", datard_o, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8; a++) reg_rd(3'(a), 32'h0, $sformatf("reset_reg%0d", a));

        // Four pixels with dv gaps
        reg_wr(REG_CTRL, 32'h1);
        repeat (3) cyc(1'b0, 1'b0, 16'h0);
        model_start();
        cyc(1'b1, 1'b0, 16'h0);
        send_pix(16'h0010);
        cyc(1'b1, 1'b0, 16'h0);
        send_pix(16'h0003);
        send_pix(16'hFFF0);
        cyc(1'b1, 1'b0, 16'h0);
        send_pix(16'h0100);
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        reg_rd(REG_PIX_CNT,   32'd4,         "f1_pix_cnt");
        reg_rd(REG_MINMAX,    32'hFFF00003,  "f1_minmax");
        reg_rd(REG_SUM,       32'h00010103,  "f1_sum");
        reg_rd(REG_FRAME_CNT, 32'd1,         "f1_frame_cnt");
        reg_rd(REG_CRC,       crc_exp(m_crc), "f1_crc");
        reg_rd(REG_STATUS,    32'h0,         "f1_status");

        // Enable in the middle of a frame: partial frame must be skipped
        reg_wr(REG_CTRL, 32'h0);
        cyc(1'b1, 1'b1, 16'h0055);
        cyc(1'b1, 1'b1, 16'h0055);
        reg_wr(REG_CTRL, 32'h1);
        repeat (4) cyc(1'b1, 1'b1, 16'h0066);
        repeat (2) cyc(1'b0, 1'b0, 16'h0);
        model_start();
        for (int i = 1; i <= 8; i++) send_pix(16'(i));
        cyc(1'b0, 1'b0, 16'h0);
        reg_rd(REG_PIX_CNT, 32'd8,        "mid_pix_cnt");
        reg_rd(REG_MINMAX,  32'h00080001, "mid_minmax");
        reg_rd(REG_SUM,     32'd36,       "mid_sum");
        check_model(32'd2, "mid");

        // Empty frame
        model_start();
        repeat (5) cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        reg_rd(REG_MINMAX, 32'h0000FFFF,          "empty_minmax");
        reg_rd(REG_CRC,    crc_exp(16'hFFFF),     "empty_crc");
        check_model(32'd3, "empty");

        // Single pixel 0x1234: known CRC value
        model_start();
        send_pix(16'h1234);
        cyc(1'b0, 1'b0, 16'h0);
        reg_rd(REG_CRC, crc_exp(16'h0EC9), "single_crc");
        check_model(32'd4, "single");

        // Disable mid-frame: frame discarded, results kept
        cyc(1'b1, 1'b1, 16'h0AAA);
        cyc(1'b1, 1'b0, 16'h0);
        reg_rd(REG_STATUS, 32'h1, "busy");
        reg_wr(REG_CTRL, 32'h0);
        cyc(1'b1, 1'b1, 16'hBBBB);
        cyc(1'b0, 1'b0, 16'h0);
        reg_rd(REG_STATUS,    32'h0,    "dis_status");
        reg_rd(REG_FRAME_CNT, 32'd4,    "dis_frame_cnt");
        reg_rd(REG_PIX_CNT,   32'd1,    "dis_pix_cnt");
        reg_rd(REG_SUM,       32'h1234, "dis_sum");
        reg_rd(REG_CTRL,      32'h0,    "dis_ctrl");
        reg_wr(REG_CTRL, 32'h1);
        repeat (3) cyc(1'b0, 1'b0, 16'h0);
        model_start();
        send_pix(16'h0005);
        cyc(1'b1, 1'b0, 16'h0);
        send_pix(16'h0007);
        cyc(1'b0, 1'b0, 16'h0);
        reg_rd(REG_MINMAX, 32'h00070005, "reen_minmax");
        check_model(32'd5, "reen");

        // dv outside fv, read-during-write, clear
        cyc(1'b0, 1'b1, 16'hAAAA);
        cyc(1'b0, 1'b0, 16'h0);
        reg_rd(REG_STATUS, 32'h4, "dv_outside");
        reg_rd(REG_CTRL,   32'h1, "rd_pre_write", 1'b1, 32'h0);
        reg_rd(REG_CTRL,   32'h0, "rd_post_write");
        reg_wr(REG_CTRL, 32'h1);
        reg_wr(REG_CTRL, 32'h3);
        reg_rd(REG_STATUS,    32'h0, "clr_status");
        reg_rd(REG_FRAME_CNT, 32'h0, "clr_frame_cnt");
        reg_rd(REG_PIX_CNT,   32'h0, "clr_pix_cnt");
        reg_rd(REG_MINMAX,    32'h0, "clr_minmax");
        reg_rd(REG_SUM,       32'h0, "clr_sum");
        reg_rd(REG_CTRL,      32'h1, "clr_enable_kept");

        // Clear on the commit edge drops the frame
        repeat (3) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h0009);
        cyc(1'b1, 1'b0, 16'h0);
        in_fv = 1'b0;
        reg_wr(REG_CTRL, 32'h3);
        cyc(1'b0, 1'b0, 16'h0);
        reg_rd(REG_FRAME_CNT, 32'h0, "clrcommit_frame_cnt");
        reg_rd(REG_PIX_CNT,   32'h0, "clrcommit_pix_cnt");
        reg_rd(REG_SUM,       32'h0, "clrcommit_sum");

        // Random frame, ~50% dv, 127 pixels
        model_start();
        cyc(1'b1, 1'b0, 16'h0);
        n = 0;
        for (int i = 0; i < 4000 && n < 127; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                send_pix(16'($urandom));
                n++;
            end else begin
                cyc(1'b1, 1'b0, 16'($urandom));
            end
        end
        cyc(1'b0, 1'b0, 16'h0);
        reg_rd(REG_PIX_CNT, 32'd127, "rand_pix_127");
        check_model(32'd1, "rand");

        // Reset in the middle of a frame
        cyc(1'b1, 1'b1, 16'h0077);
        cyc(1'b1, 1'b1, 16'h0088);
        reset_n = 1'b0;
        cyc(1'b1, 1'b1, 16'h0099);
        cyc(1'b1, 1'b0, 16'h0);
        check_val("midrst_datard", datard_o, 32'h0);
        reset_n = 1'b1;
        cyc(1'b0, 1'b0, 16'h0);
        for (int a = 0; a < 8; a++) reg_rd(3'(a), 32'h0, $sformatf("midrst_reg%0d", a));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
